lmc_prog_loader: RTL and testbench



---
 rtl/lmc_pkg.sv | 24 ++
 rtl/lmc_prog_loader_if.sv | 50 +++++
 rtl/lmc_sum_acc.sv | 32 +++
 rtl/lmc_prog_loader.sv | 169 ++++++++++++++++
 tb/tb_lmc_prog_loader.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC program loader slice.
//   - default address/data widths
//   - loader FSM state encoding
//   - LMC instruction field positions (JMP/LDA/STA flags, 4-bit operand)
package lmc_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StVerify,
        StDone
    } loader_state_e;

    // Instruction word layout
    localparam int unsigned INSTR_JMP_BIT = 7;
    localparam int unsigned INSTR_LDA_BIT = 6;
    localparam int unsigned INSTR_STA_BIT = 5;
    localparam int unsigned INSTR_OPD_MSB = 3;
    localparam int unsigned INSTR_OPD_LSB = 0;

endpackage

// File: rtl/lmc_prog_loader_if.sv
// Bundle between the program loader, its byte source and the instruction RAM.
//   start/len           : load request and word count (0 = full image)
//   in_data/in_valid/in_ready : program byte stream handshake
//   mem_we/mem_addr/mem_data  : instruction RAM write port
//   cpu_reset/busy/done/checksum : status towards the CPU and the host
// Optional macro LOADER_READBACK_EN adds mem_rdata (RAM read data) and verify_err.
// Modports: slave = loader view, master = host/RAM view.
interface lmc_prog_loader_if
    import lmc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                  start;
    logic [ADDR_WIDTH:0]   len;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] checksum;
`ifdef LOADER_READBACK_EN
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  verify_err;

    modport slave (
        input  start, len, in_data, in_valid, mem_rdata,
        output in_ready, mem_we, mem_addr, mem_data, cpu_reset, busy, done, checksum,
               verify_err
    );
    modport master (
        output start, len, in_data, in_valid, mem_rdata,
        input  in_ready, mem_we, mem_addr, mem_data, cpu_reset, busy, done, checksum,
               verify_err
    );
`else
    modport slave (
        input  start, len, in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_data, cpu_reset, busy, done, checksum
    );
    modport master (
        output start, len, in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_data, cpu_reset, busy, done, checksum
    );
`endif
endinterface

// File: rtl/lmc_sum_acc.sv
// Clearable modulo-2^DATA_WIDTH accumulator with synchronous active-low reset.
//   clk_i/rst_ni : clock, synchronous active-low reset
//   clr_i        : zero the sum (wins over en_i)
//   en_i/add_i   : add add_i to the sum at the clock edge
//   sum_o        : current sum
module lmc_sum_acc
    import lmc_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] add_i,
    output logic [DATA_WIDTH-1:0] sum_o
);
    logic [DATA_WIDTH-1:0] sum_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if (clr_i) begin
            sum_q <= '0;
        end else if (en_i) begin
            sum_q <= sum_q + add_i;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/lmc_prog_loader.sv
// Clocked writer for the LMC instruction RAM. Accepts a byte stream on a
// valid/ready handshake, writes it to addresses 0..len-1 with one cycle of
// latency, holds the CPU in reset while loading and reports a modulo checksum.
//   timer555 : clock (rising edge)
//   reset_n  : synchronous active-low reset
//   bus      : lmc_prog_loader_if.slave (request, stream, RAM port, status)
// Macro LOADER_READBACK_EN: after loading, read the image back through
// mem_rdata, compare its sum against checksum and flag verify_err.
module lmc_prog_loader
    import lmc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic              timer555,
    input logic              reset_n,
    lmc_prog_loader_if.slave bus
);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FullLen = {1'b1, {ADDR_WIDTH{1'b0}}};

    loader_state_e         state_q;
    logic [CW-1:0]         len_q;
    logic [CW-1:0]         idx_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  busy_q;
    logic                  cpu_reset_q;
    logic                  done_q;

    logic                  accept_start;
    logic                  xfer;
    logic [CW-1:0]         idx_inc;
    logic [DATA_WIDTH-1:0] checksum;

    assign accept_start = bus.start && (state_q == StIdle || state_q == StDone);
    assign xfer         = bus.in_valid && (state_q == StLoad);
    assign idx_inc      = idx_q + 1'b1;

    lmc_sum_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_checksum (
        .clk_i  (timer555),
        .rst_ni (reset_n),
        .clr_i  (accept_start),
        .en_i   (xfer),
        .add_i  (bus.in_data),
        .sum_o  (checksum)
    );

`ifdef LOADER_READBACK_EN
    // rd_active_q is low for the first VERIFY cycle, which still carries the
    // final write; reads start once mem_addr has moved to 0.
    logic                  rd_active_q;
    logic [CW-1:0]         vidx_q;
    logic                  verify_err_q;
    logic [CW-1:0]         vidx_inc;
    logic [DATA_WIDTH-1:0] rsum;
    logic [DATA_WIDTH-1:0] rsum_next;
    logic                  in_verify;

    assign in_verify = (state_q == StVerify);
    assign vidx_inc  = vidx_q + 1'b1;
    assign rsum_next = rsum + bus.mem_rdata;

    lmc_sum_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_readback (
        .clk_i  (timer555),
        .rst_ni (reset_n),
        .clr_i  (accept_start || (in_verify && !rd_active_q)),
        .en_i   (in_verify && rd_active_q),
        .add_i  (bus.mem_rdata),
        .sum_o  (rsum)
    );
`endif

    always_ff @(posedge timer555) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            len_q        <= '0;
            idx_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            cpu_reset_q  <= 1'b0;
            done_q       <= 1'b0;
`ifdef LOADER_READBACK_EN
            rd_active_q  <= 1'b0;
            vidx_q       <= '0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    mem_we_q <= 1'b0;
                    if (bus.start) begin
                        len_q       <= (bus.len == '0) ? FullLen : bus.len;
                        idx_q       <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cpu_reset_q <= 1'b1;
                        state_q     <= StLoad;
`ifdef LOADER_READBACK_EN
                        verify_err_q <= 1'b0;
`endif
                    end
                end
                StLoad: begin
                    mem_we_q <= xfer;
                    if (xfer) begin
                        mem_addr_q <= idx_q[ADDR_WIDTH-1:0];
                        mem_data_q <= bus.in_data;
                        idx_q      <= idx_inc;
                        if (idx_inc == len_q) begin
`ifdef LOADER_READBACK_EN
                            state_q     <= StVerify;
                            rd_active_q <= 1'b0;
`else
                            state_q     <= StDone;
                            busy_q      <= 1'b0;
                            cpu_reset_q <= 1'b0;
                            done_q      <= 1'b1;
`endif
                        end
                    end
                end
`ifdef LOADER_READBACK_EN
                StVerify: begin
                    mem_we_q <= 1'b0;
                    if (!rd_active_q) begin
                        rd_active_q <= 1'b1;
                        vidx_q      <= '0;
                        mem_addr_q  <= '0;
                    end else begin
                        vidx_q <= vidx_inc;
                        if (vidx_inc == len_q) begin
                            state_q      <= StDone;
                            busy_q       <= 1'b0;
                            cpu_reset_q  <= 1'b0;
                            done_q       <= 1'b1;
                            rd_active_q  <= 1'b0;
                            verify_err_q <= (rsum_next != checksum);
                        end else begin
                            mem_addr_q <= vidx_inc[ADDR_WIDTH-1:0];
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StLoad);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.cpu_reset = cpu_reset_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.checksum  = checksum;
`ifdef LOADER_READBACK_EN
    assign bus.verify_err = verify_err_q;
`endif

endmodule

// File: tb/tb_lmc_prog_loader.sv
// Directed + randomized bench for lmc_prog_loader. Expected RAM contents,
// checksums and transfer counts come from the byte list handed to each load.
module tb_lmc_prog_loader;
    logic timer555;
    logic reset_n;

    lmc_prog_loader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

    lmc_prog_loader #(
        .ADDR_WIDTH (4),
        .DATA_WIDTH (8)
    ) dut (
        .timer555 (timer555),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial timer555 = 1'b0;
    always #5 timer555 = ~timer555;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim [16];
    logic [7:0]  ram  [16];
    logic [11:0] wq [$];
    int          wc [$];
    int          cyc_no  = 0;
    int          acc_cnt = 0;
    int          lat_bad = 0;
    bit          prev_acc = 1'b0;
    bit          mon_en   = 1'b0;

`ifdef LOADER_READBACK_EN
    bit corrupt  = 1'b0;
    bit exp_verr = 1'b0;
    assign bus.mem_rdata = ram[bus.mem_addr] ^ ((corrupt && bus.mem_addr == 4'd2) ? 8'h01 : 8'h00);
`endif

    // Mid-cycle observer: logs RAM writes and checks each write strobe
    // follows exactly the handshake seen one cycle earlier.
    always @(negedge timer555) begin
        cyc_no++;
        if (mon_en) begin
            if (bus.mem_we !== prev_acc) lat_bad++;
            if (bus.mem_we === 1'b1) begin
                wq.push_back({bus.mem_addr, bus.mem_data});
                wc.push_back(cyc_no);
                ram[bus.mem_addr] = bus.mem_data;
            end
            prev_acc = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1) && (reset_n === 1'b1);
            if (prev_acc) acc_cnt++;
        end
    end

    task automatic tick();
        @(posedge timer555);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: valid held high, 1: valid alternates, 2: random valid
    task automatic run_load(input string tag, input logic [4:0] l, input int mode,
                            input bit poke_start);
        int n;
        int k;
        int cyc;
        bit v;
        n = (l == 5'd0) ? 16 : int'(l);
        k = 0;
        cyc = 0;
        wq.delete();
        wc.delete();
        acc_cnt = 0;
        bus.start = 1'b1;
        bus.len   = l;
        tick();
        bus.start = 1'b0;
        bus.len   = 5'd7;
        while (k < n && cyc < 200) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.in_valid = v;
            bus.in_data  = stim[k];
            if (poke_start && cyc == 1) bus.start = 1'b1;
            if (v && bus.in_ready === 1'b1) k++;
            tick();
            bus.start = 1'b0;
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (k != n) check({tag, "_timeout"}, 32'(k), 32'(n));
        for (int i = 0; i < 60 && bus.done !== 1'b1; i++) tick();
        tick();
        tick();
    endtask

    task automatic verify_load(input string tag, input int n, input bit consec);
        int sum;
        int errs;
        sum  = 0;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            sum += int'(stim[i]);
            if (i < wq.size() && wq[i] !== {4'(i), stim[i]}) errs++;
        end
        check({tag, "_done"},      32'(bus.done),      32'd1);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        check({tag, "_checksum"},  32'(bus.checksum),  32'(sum & 8'hFF));
        check({tag, "_wr_count"},  32'(wq.size()),     32'(n));
        check({tag, "_wr_seq"},    32'(errs),          32'd0);
        check({tag, "_xfers"},     32'(acc_cnt),       32'(n));
        if (consec && wc.size() == n) check({tag, "_back2back"}, 32'(wc[n-1] - wc[0]), 32'(n - 1));
`ifdef LOADER_READBACK_EN
        check({tag, "_verify_err"}, 32'(bus.verify_err), 32'(exp_verr));
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_outs"},
              {19'd0, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_data,
               bus.cpu_reset, bus.busy, bus.done},
              32'd0);
        check({tag, "_checksum"}, 32'(bus.checksum), 32'd0);
`ifdef LOADER_READBACK_EN
        check({tag, "_verify_err"}, 32'(bus.verify_err), 32'd0);
`endif
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        reset_n      = 1'b0;
        tick();
        tick();
        check_idle_zero("reset");
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // in_valid in IDLE must be ignored
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        for (int i = 0; i < 4; i++) tick();
        bus.in_valid = 1'b0;
        check("idle_valid_writes", 32'(wq.size()), 32'd0);
        check("idle_valid_cks",    32'(bus.checksum), 32'd0);
        check("idle_valid_busy",   32'(bus.busy), 32'd0);

        // Four-word program, valid held high
        stim[0] = 8'h41; stim[1] = 8'h25; stim[2] = 8'h83; stim[3] = 8'h10;
        run_load("len4", 5'd4, 0, 1'b0);
        verify_load("len4", 4, 1'b1);
        check("len4_cks_const", 32'(bus.checksum), 32'hF9);

        // Full image via len=0
        for (int i = 0; i < 16; i++) stim[i] = 8'hFF;
        run_load("full", 5'd0, 0, 1'b0);
        verify_load("full", 16, 1'b1);
        check("full_cks_const", 32'(bus.checksum), 32'hF0);
        check("full_last_addr", 32'(wq.size() == 16 ? wq[15][11:8] : 4'hX), 32'd15);

        // Toggling valid, plus a start poked mid-load
        stim[0] = 8'h3C; stim[1] = 8'hA7;
        run_load("toggle", 5'd2, 1, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        for (int i = 0; i < 3; i++) tick();
        bus.in_valid = 1'b0;
        tick();
        verify_load("toggle", 2, 1'b0);

        // Reset after 2 of 5 words
        wq.delete();
        acc_cnt = 0;
        stim[0] = 8'h11; stim[1] = 8'h22;
        bus.start = 1'b1;
        bus.len   = 5'd5;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim[i];
            tick();
        end
        bus.in_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        check_idle_zero("midreset");
        check("midreset_writes", 32'(wq.size()), 32'd2);
        reset_n = 1'b1;
        stim[0] = 8'h9D;
        run_load("after_reset", 5'd1, 0, 1'b0);
        verify_load("after_reset", 1, 1'b1);

        // Randomized loads
        for (int r = 0; r < 6; r++) begin
            logic [4:0] l;
            l = 5'($urandom_range(0, 16));
            for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
            run_load("rand", l, 2, 1'b0);
            verify_load("rand", (l == 5'd0) ? 16 : int'(l), 1'b0);
        end

`ifdef LOADER_READBACK_EN
        // Readback with a RAM that flips a bit at address 2
        stim[0] = 8'h41; stim[1] = 8'h25; stim[2] = 8'h83; stim[3] = 8'h10;
        corrupt  = 1'b1;
        exp_verr = 1'b1;
        run_load("rb_bad", 5'd4, 0, 1'b0);
        verify_load("rb_bad", 4, 1'b1);
        corrupt  = 1'b0;
        exp_verr = 1'b0;
        run_load("rb_good", 5'd4, 0, 1'b0);
        verify_load("rb_good", 4, 1'b1);
`endif

        check("mem_we_latency", 32'(lat_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
